// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - arriskv fetch stage: PC generation, imem requests, in-order response buffer
// Optional ARRISKV_FETCH_MISALIGN_CHK_EN: misaligned redirect target halts fetch and sets o_misaligned.
module instr_fetch #(
   parameter int unsigned        wd_instr_p   = 32,
   parameter int unsigned        wd_pc_p      = 32,
   parameter logic [wd_pc_p-1:0] reset_pc_p   = '0,
   parameter int unsigned        fifo_depth_p = 2,
   parameter int unsigned        max_outst_p  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  o_imem_req_valid,
   input  logic                  i_imem_req_ready,
   output logic [wd_pc_p-1:0]    o_imem_req_addr,
   input  logic                  i_imem_rsp_valid,
   input  logic [wd_instr_p-1:0] i_imem_rsp_data,
   input  logic                  i_stall,
   input  logic                  i_redirect,
   input  logic [wd_pc_p-1:0]    i_redirect_pc,
   output logic [wd_instr_p-1:0] o_instr,
   output logic [wd_pc_p-1:0]    o_pc,
   output logic                  o_valid
`ifdef ARRISKV_FETCH_MISALIGN_CHK_EN
   ,
   output logic                  o_misaligned
`endif
);

   localparam int unsigned aw_lp = (fifo_depth_p > 1) ? $clog2(fifo_depth_p) : 1;
   localparam int unsigned cw_lp = aw_lp + 1;
   localparam logic [cw_lp:0]      depth_lp     = (cw_lp+1)'(fifo_depth_p);
   localparam logic [cw_lp-1:0]    max_outst_lp = cw_lp'(max_outst_p);
   localparam logic [wd_instr_p-1:0] nop_lp     = wd_instr_p'(32'h0000_0013);
   localparam logic [wd_pc_p-1:0]  pc_step_lp   = wd_pc_p'(4);

   logic [wd_pc_p-1:0]    fetch_pc, rsp_pc, redir_pc;
   logic [cw_lp-1:0]      outst, drop_cnt, fifo_cnt;
   logic [aw_lp-1:0]      rd_ptr, wr_ptr;
   logic [wd_instr_p-1:0] mem_instr [fifo_depth_p];
   logic [wd_pc_p-1:0]    mem_pc    [fifo_depth_p];
   logic                  halt, fire, rsp_keep, fifo_empty, pop, bypass, push;

`ifdef ARRISKV_FETCH_MISALIGN_CHK_EN
   logic misaligned;

   always_ff @(posedge clk) begin
      if (!rst_n)
         misaligned <= 1'b0;
      else if (i_redirect && (i_redirect_pc[1:0] != 2'b00))
         misaligned <= 1'b1;
   end

   assign o_misaligned = misaligned;
   assign halt         = misaligned;
`else
   assign halt = 1'b0;
`endif

   assign redir_pc        = i_redirect_pc & ~wd_pc_p'(3);
   assign o_imem_req_addr = fetch_pc;
   assign fifo_empty      = (fifo_cnt == '0);

   // Every request in flight reserves a FIFO slot, so pushes can never overflow.
   assign o_imem_req_valid = rst_n && !i_redirect && !halt
                             && (({1'b0, outst} + {1'b0, fifo_cnt}) < depth_lp)
                             && (outst < max_outst_lp);
   assign fire     = o_imem_req_valid && i_imem_req_ready;
   assign rsp_keep = i_imem_rsp_valid && (drop_cnt == '0) && !i_redirect && !halt;
   assign pop      = !i_stall && !fifo_empty;
   assign bypass   = !i_stall && fifo_empty && rsp_keep;
   assign push     = rsp_keep && !bypass;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= i_imem_rsp_data;
         mem_pc[wr_ptr]    <= rsp_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc <= reset_pc_p;
         rsp_pc   <= reset_pc_p;
         outst    <= '0;
         drop_cnt <= '0;
         fifo_cnt <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         o_instr  <= nop_lp;
         o_pc     <= reset_pc_p;
         o_valid  <= 1'b0;
      end else begin
         outst <= outst + cw_lp'(fire) - cw_lp'(i_imem_rsp_valid);
         if (i_redirect) begin
            // Everything still in flight belongs to the old path.
            fetch_pc <= redir_pc;
            rsp_pc   <= redir_pc;
            drop_cnt <= outst - cw_lp'(i_imem_rsp_valid);
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            o_instr  <= nop_lp;
            o_valid  <= 1'b0;
         end else begin
            if (fire)
               fetch_pc <= fetch_pc + pc_step_lp;
            if (i_imem_rsp_valid && (drop_cnt != '0))
               drop_cnt <= drop_cnt - 1'b1;
            if (rsp_keep)
               rsp_pc <= rsp_pc + pc_step_lp;
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + cw_lp'(push) - cw_lp'(pop);
            if (pop) begin
               o_instr <= mem_instr[rd_ptr];
               o_pc    <= mem_pc[rd_ptr];
               o_valid <= 1'b1;
               rd_ptr  <= rd_ptr + 1'b1;
            end else if (bypass) begin
               o_instr <= i_imem_rsp_data;
               o_pc    <= rsp_pc;
               o_valid <= 1'b1;
            end else if (!i_stall) begin
               o_instr <= nop_lp;
               o_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with a latency-configurable memory model
module tb_instr_fetch;

   localparam logic [31:0] nop_c = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready;
   logic [31:0] o_imem_req_addr;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        i_stall;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        o_valid;
`ifdef ARRISKV_FETCH_MISALIGN_CHK_EN
   logic        o_misaligned;
`endif

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_req_addr  (o_imem_req_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rsp_data  (i_imem_rsp_data),
      .i_stall          (i_stall),
      .i_redirect       (i_redirect),
      .i_redirect_pc    (i_redirect_pc),
      .o_instr          (o_instr),
      .o_pc             (o_pc),
      .o_valid          (o_valid)
`ifdef ARRISKV_FETCH_MISALIGN_CHK_EN
      ,
      .o_misaligned     (o_misaligned)
`endif
   );

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   mreq_t       memq[$];
   exp_t        sb[$];
   int          cyc = 0;
   int          lat = 1;
   int          checks = 0;
   int          failures = 0;
   int          nfire = 0;
   logic [31:0] model_pc = 32'h0;
   logic        last_fire;
   logic [31:0] last_fire_addr;
   logic        last_cons;
   logic [31:0] last_cons_pc;

   function automatic logic [31:0] memdata(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   // One clock: memory model drives the response, then fires and consumed outputs are scored.
   task automatic cycle();
      exp_t  e;
      mreq_t m;
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = 32'h0;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         m = memq.pop_front();
         i_imem_rsp_valid = 1'b1;
         i_imem_rsp_data  = memdata(m.addr);
      end
      #1;
      last_fire      = o_imem_req_valid && i_imem_req_ready;
      last_fire_addr = o_imem_req_addr;
      last_cons      = rst_n && o_valid && !i_stall && !i_redirect;
      last_cons_pc   = o_pc;
      if (i_redirect) begin
         checks++;
         if (o_imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL redirect_req_valid: got=%b want=0", o_imem_req_valid);
         end
      end
      if (last_fire) begin
         checks++;
         if (o_imem_req_addr !== model_pc) begin
            failures++;
            $display("FAIL req_addr: got=%h want=%h", o_imem_req_addr, model_pc);
         end
         m.addr = o_imem_req_addr;
         m.due  = cyc + lat;
         memq.push_back(m);
         e.pc    = model_pc;
         e.instr = memdata(model_pc);
         sb.push_back(e);
         model_pc = model_pc + 32'd4;
         nfire++;
      end
      if (last_cons) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_instr: got pc=%h instr=%h want=none", o_pc, o_instr);
         end else begin
            e = sb.pop_front();
            if (o_pc !== e.pc || o_instr !== e.instr) begin
               failures++;
               $display("FAIL instr_stream: got pc=%h instr=%h want pc=%h instr=%h",
                        o_pc, o_instr, e.pc, e.instr);
            end
         end
      end
      if (i_redirect) begin
         sb.delete();
         model_pc = i_redirect_pc & ~32'd3;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      i_imem_req_ready = 1'b0;
      i_stall          = 1'b0;
      i_redirect       = 1'b0;
      while ((memq.size() > 0 || sb.size() > 0) && n < 60) begin
         cycle();
         n++;
      end
      cycle();
      checks++;
      if (memq.size() > 0 || sb.size() > 0) begin
         failures++;
         $display("FAIL drain: got pending=%0d expected=%0d want 0/0", memq.size(), sb.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_stall = 1'b0;
      i_redirect = 1'b0;
      i_redirect_pc = 32'h0;
      i_imem_req_ready = 1'b1;
      memq.delete();
      sb.delete();
      model_pc = 32'h0;
      repeat (3) cycle();
      checks++;
      if (o_imem_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_req_valid: got=%b want=0", o_imem_req_valid);
      end
      checks++;
      if (o_imem_req_addr !== 32'h0) begin
         failures++;
         $display("FAIL reset_req_addr: got=%h want=0", o_imem_req_addr);
      end
      checks++;
      if (o_valid !== 1'b0 || o_instr !== nop_c || o_pc !== 32'h0) begin
         failures++;
         $display("FAIL reset_output: got v=%b instr=%h pc=%h want v=0 instr=%h pc=0",
                  o_valid, o_instr, o_pc, nop_c);
      end
`ifdef ARRISKV_FETCH_MISALIGN_CHK_EN
      checks++;
      if (o_misaligned !== 1'b0) begin
         failures++;
         $display("FAIL reset_misaligned: got=%b want=0", o_misaligned);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      int          fire_cyc = -1;
      int          valid_cyc = -1;
      int          n0;
      logic [31:0] first_pc = 32'hFFFF_FFFF;
      lat = 1;
      i_imem_req_ready = 1'b1;
      i_stall = 1'b0;
      n0 = nfire;
      for (int k = 0; k < 12; k++) begin
         if (valid_cyc < 0 && o_valid) begin
            valid_cyc = cyc;
            first_pc  = o_pc;
         end
         cycle();
         if (fire_cyc < 0 && last_fire) fire_cyc = cyc - 1;
      end
      checks++;
      if (valid_cyc - fire_cyc != 2) begin
         failures++;
         $display("FAIL first_valid_latency: got=%0d want=2", valid_cyc - fire_cyc);
      end
      checks++;
      if (first_pc !== 32'h0) begin
         failures++;
         $display("FAIL first_pc: got=%h want=0", first_pc);
      end
      checks++;
      if (nfire - n0 != 12) begin
         failures++;
         $display("FAIL stream_rate: got=%0d want=12", nfire - n0);
      end
      drain();
   endtask

   task automatic test_stall();
      logic [31:0] hold_i, hold_p;
      int          n0;
      lat = 1;
      i_imem_req_ready = 1'b1;
      i_stall = 1'b0;
      repeat (3) cycle();
      checks++;
      if (o_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_setup_valid: got=%b want=1", o_valid);
      end
      i_stall = 1'b1;
      hold_i = o_instr;
      hold_p = o_pc;
      n0 = nfire;
      for (int k = 0; k < 5; k++) begin
         cycle();
         checks++;
         if (o_instr !== hold_i || o_pc !== hold_p || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: got instr=%h pc=%h v=%b want instr=%h pc=%h v=1",
                     o_instr, o_pc, o_valid, hold_i, hold_p);
         end
      end
      checks++;
      if (o_imem_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL stall_req_valid: got=%b want=0", o_imem_req_valid);
      end
      checks++;
      if (nfire - n0 > 2) begin
         failures++;
         $display("FAIL stall_fires: got=%0d want<=2", nfire - n0);
      end
      i_stall = 1'b0;
      repeat (4) cycle();
      drain();
   endtask

   task automatic test_redirect();
      logic [31:0] f_addr = 32'hFFFF_FFFF;
      logic [31:0] c_pc = 32'hFFFF_FFFF;
      lat = 3;
      i_imem_req_ready = 1'b1;
      repeat (2) cycle();
      checks++;
      if (o_imem_req_valid !== 1'b0 || memq.size() != 2) begin
         failures++;
         $display("FAIL outst_limit: got v=%b outst=%0d want v=0 outst=2", o_imem_req_valid, memq.size());
      end
      i_redirect = 1'b1;
      i_redirect_pc = 32'h0000_0100;
      cycle();
      i_redirect = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (last_fire && f_addr === 32'hFFFF_FFFF) f_addr = last_fire_addr;
         if (last_cons && c_pc === 32'hFFFF_FFFF) c_pc = last_cons_pc;
      end
      checks++;
      if (f_addr !== 32'h0000_0100) begin
         failures++;
         $display("FAIL redirect_addr: got=%h want=00000100", f_addr);
      end
      checks++;
      if (c_pc !== 32'h0000_0100) begin
         failures++;
         $display("FAIL redirect_first_pc: got=%h want=00000100", c_pc);
      end
      drain();
   endtask

   task automatic test_redirect_rsp_stall();
      logic [31:0] c_pc = 32'hFFFF_FFFF;
      lat = 3;
      i_imem_req_ready = 1'b1;
      repeat (3) cycle();
      i_redirect = 1'b1;
      i_redirect_pc = 32'h0000_0200;
      i_stall = 1'b1;
      cycle();
      checks++;
      if (o_valid !== 1'b0 || o_instr !== nop_c) begin
         failures++;
         $display("FAIL redirect_stall_out: got v=%b instr=%h want v=0 instr=%h", o_valid, o_instr, nop_c);
      end
      i_redirect = 1'b0;
      i_stall = 1'b0;
      cycle();
      i_redirect = 1'b1;
      i_redirect_pc = 32'h0000_0300;
      cycle();
      i_redirect_pc = 32'h0000_0400;
      cycle();
      i_redirect = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (last_cons && c_pc === 32'hFFFF_FFFF) c_pc = last_cons_pc;
      end
      checks++;
      if (c_pc !== 32'h0000_0400) begin
         failures++;
         $display("FAIL b2b_redirect_pc: got=%h want=00000400", c_pc);
      end
      drain();
   endtask

   task automatic test_ready_toggle();
      logic        pend = 1'b0;
      logic [31:0] pend_addr = 32'h0;
      lat = 3;
      i_stall = 1'b0;
      for (int k = 0; k < 18; k++) begin
         i_imem_req_ready = ((k % 3) != 1);
         if (pend) begin
            checks++;
            if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== pend_addr) begin
               failures++;
               $display("FAIL addr_stable: got v=%b addr=%h want v=1 addr=%h",
                        o_imem_req_valid, o_imem_req_addr, pend_addr);
            end
         end
         pend      = o_imem_req_valid && !i_imem_req_ready;
         pend_addr = o_imem_req_addr;
         cycle();
      end
      drain();
   endtask

`ifdef ARRISKV_FETCH_MISALIGN_CHK_EN
   task automatic test_misaligned();
      i_redirect = 1'b1;
      i_redirect_pc = 32'h0000_0102;
      cycle();
      i_redirect = 1'b0;
      i_imem_req_ready = 1'b1;
      checks++;
      if (o_misaligned !== 1'b1) begin
         failures++;
         $display("FAIL misaligned_flag: got=%b want=1", o_misaligned);
      end
      for (int k = 0; k < 8; k++) begin
         cycle();
         checks++;
         if (o_imem_req_valid !== 1'b0 || o_valid !== 1'b0 || o_misaligned !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_halt: got req=%b v=%b mis=%b want 0/0/1",
                     o_imem_req_valid, o_valid, o_misaligned);
         end
      end
   endtask
`else
   task automatic test_align();
      logic [31:0] f_addr = 32'hFFFF_FFFF;
      i_redirect = 1'b1;
      i_redirect_pc = 32'h0000_0102;
      cycle();
      i_redirect = 1'b0;
      i_imem_req_ready = 1'b1;
      lat = 1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (last_fire && f_addr === 32'hFFFF_FFFF) f_addr = last_fire_addr;
      end
      checks++;
      if (f_addr !== 32'h0000_0100) begin
         failures++;
         $display("FAIL align_addr: got=%h want=00000100", f_addr);
      end
      drain();
   endtask
`endif

   task automatic test_reset_mid();
      lat = 1;
      i_imem_req_ready = 1'b1;
      repeat (4) cycle();
      test_reset();
      lat = 1;
      i_imem_req_ready = 1'b1;
      repeat (6) cycle();
      drain();
   endtask

   initial begin
      rst_n = 1'b0;
      i_imem_req_ready = 1'b0;
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data = 32'h0;
      i_stall = 1'b0;
      i_redirect = 1'b0;
      i_redirect_pc = 32'h0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_rsp_stall();
      test_ready_toggle();
`ifdef ARRISKV_FETCH_MISALIGN_CHK_EN
      test_misaligned();
`else
      test_align();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
